fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the single-cycle/teaching MIPS core; sits directly upstream of the
//  asynchronous instruction ROM. Holds the PC, drives the ROM word address, and registers
//  {pc, inst} into a one-entry output buffer for decode under a valid/allowin handshake.
//  Applies branch/jump redirects and halts on misaligned redirect targets.
// PARAMETERS
//  ADDR_W    5             ROM word-address width; rom_addr = pc[ADDR_W+1:2]
//  RESET_PC  32'h0000_0000 PC loaded on reset (must be word aligned)
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  resetn         in   1   synchronous reset, active low
//  rom_addr       out  ADDR_W  word address to ROM, = pc[ADDR_W+1:2] (combinational)
//  rom_inst       in   32  ROM read data, valid same cycle as rom_addr (async read)
//  ds_allowin     in   1   decode can accept the output buffer this cycle
//  br_valid       in   1   redirect request from decode/execute
//  br_target      in   32  redirect byte address
//  fs_to_ds_valid out  1   output buffer holds a valid instruction
//  fs_pc          out  32  byte PC of buffered instruction
//  fs_inst        out  32  buffered instruction word
//  fs_addr_err    out  1   sticky: misaligned redirect seen, stage halted
//  fs_inst_cnt    out  32  count of instructions handed to decode
// BEHAVIOUR
//  Reset (resetn==0 at edge, any state, mid-operation included): pc=RESET_PC, state=BOOT,
//   fs_to_ds_valid=0, fs_pc=0, fs_inst=0, fs_addr_err=0, fs_inst_cnt=0.
//  States: BOOT -> FETCH unconditionally after one cycle (one bubble, no capture in BOOT).
//   FETCH -> HALT on br_valid with br_target[1:0]!=0. HALT exits only via reset.
//  Handshake: transfer to decode = fs_to_ds_valid & ds_allowin. fs_inst_cnt += 1 per transfer
//   (wraps mod 2^32). Buffer contents hold stable while valid & !ds_allowin.
//  Capture (FETCH, no br_valid): when !fs_to_ds_valid | ds_allowin:
//   fs_pc<=pc, fs_inst<=rom_inst, fs_to_ds_valid<=1, pc<=pc+4. Latency pc->fs_inst: 1 cycle.
//   Otherwise pc and buffer hold (backpressure).
//  Redirect (FETCH, br_valid, aligned target): pc<=br_target, fs_to_ds_valid<=0 (wrong-path
//   flush), no capture that cycle; priority over capture and backpressure. A transfer in the
//   same cycle still counts. First target instruction appears 1 cycle after redirect edge.
//  Misaligned redirect: state<=HALT, fs_addr_err<=1, fs_to_ds_valid<=0, pc unchanged.
//  HALT: no captures, no pc change, br_valid ignored, outputs hold except fs_to_ds_valid=0.
//  PC arithmetic: 32-bit, pc+4 wraps 32'hFFFF_FFFC -> 0. Word indices beyond ROM contents
//   pass through whatever ROM returns (32'h0 = nop); no error raised.
//  No combinational path from ds_allowin/br_valid to rom_addr or any output.
// TESTING
//  Reset then run, ds_allowin=1: cycle1 BOOT no valid; then fs_pc=0 inst=24010001,
//   fs_pc=4 inst=00011100, fs_pc=8 inst=00411821 on consecutive cycles; cnt increments each.
//  Backpressure: hold ds_allowin=0 3 cycles with fs_pc=0x0C valid -> fs_pc/fs_inst=00022082
//   stable, rom_addr stays 4, cnt frozen; release -> 0x10 next cycle.
//  Redirect: br_valid with target 0x34 while buffer holds 0x30 -> buffer flushed, next valid
//   fs_pc=0x34 inst=8C2A0013; target 0x00 from 0x58 -> restarts at 24010001.
//  Misaligned: br_target=0x36 -> fs_addr_err=1, valid=0 forever, further br_valid ignored;
//   resetn low one edge -> fs_addr_err=0, cnt=0, resumes at 0x00.
//  Reset mid-stream with valid & !ds_allowin -> all outputs at reset values next edge.
//  Wrap/out-of-range: force redirect to 0xFFFF_FFFC -> next fs_pc=0x0000_0000 after it;
//   pc=0x5C (index 23) -> fs_inst=0, no error.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the teaching MIPS core.
// Holds the PC, addresses the asynchronous instruction ROM and registers
// {pc, inst} into a one-entry output buffer handed to decode under a
// valid/allowin handshake. Branch/jump redirects flush the buffer; a
// misaligned redirect target halts the stage until reset.
module fetch_stage #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              ds_allowin,
  input  logic              br_valid,
  input  logic [31:0]       br_target,
  output logic              fs_to_ds_valid,
  output logic [31:0]       fs_pc,
  output logic [31:0]       fs_inst,
  output logic              fs_addr_err,
  output logic [31:0]       fs_inst_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;

  logic        transfer;
  logic        br_aligned;
  logic        do_capture;
  logic        do_redirect;
  logic        do_halt;

  // ROM word address comes straight from the PC register, so no input
  // reaches it combinationally.
  assign rom_addr   = pc[ADDR_W+1:2];
  assign transfer   = fs_to_ds_valid & ds_allowin;
  assign br_aligned = (br_target[1:0] == 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one boot bubble, then fetch until a misaligned redirect
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: if (br_valid && !br_aligned) state_nxt = S_HALT;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_BOOT;
    endcase
  end

  // Control decode: redirect beats capture, capture only when the buffer frees
  always_comb begin
    do_capture  = 1'b0;
    do_redirect = 1'b0;
    do_halt     = 1'b0;
    case (state)
      S_FETCH: begin
        if (br_valid) begin
          do_redirect = br_aligned;
          do_halt     = !br_aligned;
        end else begin
          do_capture  = !fs_to_ds_valid || ds_allowin;
        end
      end
      default: ;
    endcase
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc <= RESET_PC;
    end else if (do_redirect) begin
      pc <= br_target;
    end else if (do_capture) begin
      pc <= pc + 32'd4;
    end
  end

  // Output buffer: flushed on any redirect, loaded on capture, else held
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_to_ds_valid <= 1'b0;
      fs_pc          <= '0;
      fs_inst        <= '0;
    end else if (do_redirect || do_halt) begin
      fs_to_ds_valid <= 1'b0;
    end else if (do_capture) begin
      fs_to_ds_valid <= 1'b1;
      fs_pc          <= pc;
      fs_inst        <= rom_inst;
    end
  end

  // Sticky misaligned-target flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_addr_err <= 1'b0;
    end else if (do_halt) begin
      fs_addr_err <= 1'b1;
    end
  end

  // Handed-off instruction count; a transfer coinciding with a redirect
  // still completed, so it is counted independently of the state decode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_inst_cnt <= '0;
    end else if (transfer) begin
      fs_inst_cnt <= fs_inst_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized run,
// all checked against a behavioural model of the fetch stage and ROM.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk;
  logic        resetn;
  logic [4:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        ds_allowin;
  logic        br_valid;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_addr_err;
  logic [31:0] fs_inst_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] rom [0:31];
  assign rom_inst = rom[rom_addr];

  // Behavioural model state
  logic [31:0] m_pc, m_fs_pc, m_fs_inst, m_cnt;
  logic        m_valid, m_err, m_boot, m_halt;

  fetch_stage #(.ADDR_W(5), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .resetn(resetn), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .ds_allowin(ds_allowin), .br_valid(br_valid), .br_target(br_target),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
    .fs_addr_err(fs_addr_err), .fs_inst_cnt(fs_inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Apply inputs, take one rising edge, advance the model, settle at negedge.
  task automatic advance(input logic rst_n, input logic allow, input logic brv,
                         input logic [31:0] tgt);
    logic [31:0] word;
    resetn = rst_n; ds_allowin = allow; br_valid = brv; br_target = tgt;
    word = rom[m_pc[6:2]];
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 1'b0; m_fs_pc = 32'h0; m_fs_inst = 32'h0;
      m_err = 1'b0; m_cnt = 32'h0; m_boot = 1'b1; m_halt = 1'b0;
    end else begin
      if (m_valid && allow) m_cnt = m_cnt + 1;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_halt) begin
        if (brv) begin
          if (tgt % 4 != 0) begin
            m_halt = 1'b1; m_err = 1'b1;
          end else begin
            m_pc = tgt;
          end
          m_valid = 1'b0;
        end else if (!m_valid || allow) begin
          m_fs_pc = m_pc; m_fs_inst = word; m_valid = 1'b1; m_pc = m_pc + 4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    advance(1'b0, 1'b1, 1'b0, 32'h0);
    advance(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", fs_to_ds_valid); end
    total++; if (fs_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", fs_pc); end
    total++; if (fs_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", fs_inst); end
    total++; if (fs_addr_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", fs_addr_err); end
    total++; if (fs_inst_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", fs_inst_cnt); end
    total++; if (rom_addr !== 5'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", rom_addr); end
  endtask

  task automatic test_startup;
    logic [31:0] exp_inst [0:2];
    exp_inst[0] = 32'h24010001; exp_inst[1] = 32'h00011100; exp_inst[2] = 32'h00411821;
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL boot_bubble got=%b exp=0", fs_to_ds_valid); end
    for (int i = 0; i < 3; i++) begin
      advance(1'b1, 1'b1, 1'b0, 32'h0);
      total++; if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL start_valid[%0d] got=%b exp=1", i, fs_to_ds_valid); end
      total++; if (fs_pc !== 32'(i * 4)) begin bad++; $display("FAIL start_pc[%0d] got=%h exp=%h", i, fs_pc, 32'(i * 4)); end
      total++; if (fs_inst !== exp_inst[i]) begin bad++; $display("FAIL start_inst[%0d] got=%h exp=%h", i, fs_inst, exp_inst[i]); end
      total++; if (fs_inst_cnt !== 32'(i)) begin bad++; $display("FAIL start_cnt[%0d] got=%0d exp=%0d", i, fs_inst_cnt, i); end
    end
  endtask

  task automatic test_backpressure;
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_pc !== 32'h0C) begin bad++; $display("FAIL bp_pre_pc got=%h exp=0c", fs_pc); end
    for (int i = 0; i < 3; i++) begin
      advance(1'b1, 1'b0, 1'b0, 32'h0);
      total++; if (fs_pc !== 32'h0C || fs_inst !== 32'h00022082 || fs_to_ds_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got=%h/%h/%b exp=0000000c/00022082/1", i, fs_pc, fs_inst, fs_to_ds_valid); end
      total++; if (rom_addr !== 5'd4) begin bad++; $display("FAIL bp_addr[%0d] got=%0d exp=4", i, rom_addr); end
      total++; if (fs_inst_cnt !== 32'd3) begin bad++; $display("FAIL bp_cnt[%0d] got=%0d exp=3", i, fs_inst_cnt); end
    end
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_pc !== 32'h10 || fs_inst !== rom[4]) begin bad++; $display("FAIL bp_release got=%h/%h exp=00000010/%h", fs_pc, fs_inst, rom[4]); end
    total++; if (fs_inst_cnt !== 32'd4) begin bad++; $display("FAIL bp_release_cnt got=%0d exp=4", fs_inst_cnt); end
  endtask

  task automatic test_redirect;
    for (int i = 0; i < 40 && m_fs_pc != 32'h30; i++) advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_pc !== 32'h30) begin bad++; $display("FAIL redir_reach got=%h exp=30", fs_pc); end
    advance(1'b1, 1'b1, 1'b1, 32'h34);
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", fs_to_ds_valid); end
    total++; if (fs_inst_cnt !== m_cnt) begin bad++; $display("FAIL redir_cnt got=%0d exp=%0d", fs_inst_cnt, m_cnt); end
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_pc !== 32'h34 || fs_inst !== 32'h8C2A0013 || fs_to_ds_valid !== 1'b1) begin
      bad++; $display("FAIL redir_target got=%h/%h/%b exp=00000034/8c2a0013/1", fs_pc, fs_inst, fs_to_ds_valid); end
    for (int i = 0; i < 40 && m_fs_pc != 32'h58; i++) advance(1'b1, 1'b1, 1'b0, 32'h0);
    advance(1'b1, 1'b1, 1'b1, 32'h0);
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL redir0_flush got=%b exp=0", fs_to_ds_valid); end
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_pc !== 32'h0 || fs_inst !== 32'h24010001) begin bad++; $display("FAIL redir0_target got=%h/%h exp=00000000/24010001", fs_pc, fs_inst); end
  endtask

  task automatic test_misaligned;
    logic [31:0] held_pc;
    logic [4:0]  held_addr;
    advance(1'b1, 1'b1, 1'b1, 32'h36);
    total++; if (fs_addr_err !== 1'b1 || fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL mis_halt got=%b/%b exp=1/0", fs_addr_err, fs_to_ds_valid); end
    held_pc = m_fs_pc; held_addr = m_pc[6:2];
    for (int i = 0; i < 6; i++) begin
      advance(1'b1, 1'($urandom), 1'b1, ($urandom % 32) * 4);
      total++; if (fs_addr_err !== 1'b1 || fs_to_ds_valid !== 1'b0 || rom_addr !== held_addr || fs_pc !== held_pc) begin
        bad++; $display("FAIL mis_stuck[%0d] got=%b/%b/%h/%h exp=1/0/%h/%h", i, fs_addr_err, fs_to_ds_valid, rom_addr, fs_pc, held_addr, held_pc); end
    end
    advance(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (fs_addr_err !== 1'b0 || fs_inst_cnt !== 32'h0) begin bad++; $display("FAIL mis_reset got=%b/%0d exp=0/0", fs_addr_err, fs_inst_cnt); end
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_pc !== 32'h0 || fs_inst !== 32'h24010001 || fs_to_ds_valid !== 1'b1) begin
      bad++; $display("FAIL mis_resume got=%h/%h/%b exp=00000000/24010001/1", fs_pc, fs_inst, fs_to_ds_valid); end
  endtask

  task automatic test_reset_mid;
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    advance(1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", fs_to_ds_valid); end
    advance(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (fs_to_ds_valid !== 1'b0 || fs_pc !== 32'h0 || fs_inst !== 32'h0 || fs_addr_err !== 1'b0 || fs_inst_cnt !== 32'h0 || rom_addr !== 5'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%h/%b/%h/%h exp=0/0/0/0/0/0", fs_to_ds_valid, fs_pc, fs_inst, fs_addr_err, fs_inst_cnt, rom_addr); end
  endtask

  task automatic test_wrap;
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    advance(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_pc !== 32'hFFFF_FFFC || fs_inst !== rom[31]) begin bad++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/%h", fs_pc, fs_inst, rom[31]); end
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_pc !== 32'h0 || fs_inst !== 32'h24010001) begin bad++; $display("FAIL wrap_zero got=%h/%h exp=00000000/24010001", fs_pc, fs_inst); end
    advance(1'b1, 1'b1, 1'b1, 32'h5C);
    advance(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (fs_pc !== 32'h5C || fs_inst !== 32'h0 || fs_addr_err !== 1'b0) begin
      bad++; $display("FAIL oor_nop got=%h/%h/%b exp=0000005c/00000000/0", fs_pc, fs_inst, fs_addr_err); end
  endtask

  task automatic test_random;
    logic        r, a, b;
    logic [31:0] t;
    int unsigned sel;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom % 80) != 0;
      a = ($urandom % 4) != 0;
      b = ($urandom % 8) == 0;
      sel = $urandom % 10;
      if (sel < 7)      t = ($urandom % 32) * 4;
      else if (sel < 9) t = {$urandom, 2'b00} ;
      else              t = {$urandom, 2'b00} | 32'($urandom_range(1, 3));
      advance(r, a, b, t);
      total++; if (fs_to_ds_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, fs_to_ds_valid, m_valid); end
      total++; if (fs_pc !== m_fs_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, fs_pc, m_fs_pc); end
      total++; if (fs_inst !== m_fs_inst) begin bad++; $display("FAIL rnd_inst[%0d] got=%h exp=%h", i, fs_inst, m_fs_inst); end
      total++; if (fs_addr_err !== m_err) begin bad++; $display("FAIL rnd_err[%0d] got=%b exp=%b", i, fs_addr_err, m_err); end
      total++; if (fs_inst_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, fs_inst_cnt, m_cnt); end
      total++; if (rom_addr !== m_pc[6:2]) begin bad++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, rom_addr, m_pc[6:2]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    rom[0]  = 32'h24010001;
    rom[1]  = 32'h00011100;
    rom[2]  = 32'h00411821;
    rom[3]  = 32'h00022082;
    rom[13] = 32'h8C2A0013;
    rom[23] = 32'h00000000;
    m_pc = 32'h0; m_fs_pc = 32'h0; m_fs_inst = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_err = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
    resetn = 1'b0; ds_allowin = 1'b1; br_valid = 1'b0; br_target = 32'h0;
    @(negedge clk);
    test_reset;
    test_startup;
    test_backpressure;
    test_redirect;
    test_misaligned;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
